// File: rtl/req_arb_fsm.sv
// Round-robin request/acknowledge controller: N_CH requesters share one READ/WRITE target.
// Define REQ_ARB_FSM_TIMEOUT_EN to build the watchdog (ERR state and timeout pulse).
module req_arb_fsm #(
  parameter int unsigned N_CH    = 4,
  parameter int unsigned TIMEOUT = 16,
  localparam int unsigned ID_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic [N_CH-1:0] req,
  input  logic [N_CH-1:0] we,
  input  logic            ack,
  output logic            idle,
  output logic            read,
  output logic            write,
  output logic [N_CH-1:0] grant,
  output logic [ID_W-1:0] grant_id,
  output logic            timeout
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StRead  = 2'd1;
  localparam logic [1:0] StWrite = 2'd2;
  localparam logic [1:0] StErr   = 2'd3;

  logic [1:0]      state_q, state_d;
  logic [N_CH-1:0] grant_q, grant_d;
  logic [ID_W-1:0] grant_id_q, grant_id_d;
  logic [ID_W-1:0] last_q, last_d;

  logic            win_vld;
  logic            win_we;
  logic [ID_W-1:0] win_id;
  logic [N_CH-1:0] win_oh;

  // Two descending passes: the lowest requester above last wins, otherwise the lowest at or
  // below last, which is the first set bit searching upward from last+1 with wrap.
  always_comb begin
    win_vld = 1'b0;
    win_we  = 1'b0;
    win_id  = '0;
    win_oh  = '0;
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (req[c] && (ID_W'(c) <= last_q)) begin
        win_vld   = 1'b1;
        win_we    = we[c];
        win_id    = ID_W'(c);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
    for (int c = N_CH - 1; c >= 0; c--) begin
      if (req[c] && (ID_W'(c) > last_q)) begin
        win_vld   = 1'b1;
        win_we    = we[c];
        win_id    = ID_W'(c);
        win_oh    = '0;
        win_oh[c] = 1'b1;
      end
    end
  end

`ifdef REQ_ARB_FSM_TIMEOUT_EN
  localparam int unsigned CNT_W = $clog2(TIMEOUT);
  localparam logic [CNT_W-1:0] CntMax = CNT_W'(TIMEOUT - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             wd_expired;

  assign wd_expired = (cnt_q == CntMax);

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == StIdle) begin
      cnt_d = '0;
    end else if (((state_q == StRead) || (state_q == StWrite)) && !ack) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign timeout = (state_q == StErr);
`else
  logic wd_expired;
  logic unused_timeout;

  assign wd_expired     = 1'b0;
  assign unused_timeout = ^TIMEOUT;
  assign timeout        = 1'b0;
`endif

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    case (state_q)
      StIdle: begin
        if (win_vld) begin
          state_d    = win_we ? StWrite : StRead;
          grant_d    = win_oh;
          grant_id_d = win_id;
          last_d     = win_id;
        end
      end
      StRead, StWrite: begin
        // ack wins over an expiring watchdog on the same cycle
        if (ack) begin
          state_d = StIdle;
          grant_d = '0;
        end else if (wd_expired) begin
          state_d = StErr;
          grant_d = '0;
        end
      end
      default: begin
        state_d = StIdle;
        grant_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= ID_W'(N_CH - 1);
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
    end
  end

  assign idle     = (state_q == StIdle);
  assign read     = (state_q == StRead);
  assign write    = (state_q == StWrite);
  assign grant    = grant_q;
  assign grant_id = grant_id_q;

endmodule

// File: tb/tb_req_arb_fsm.sv
// Directed bench for req_arb_fsm with N_CH=4, TIMEOUT=16; watchdog checks follow the build macro.
module tb_req_arb_fsm;

  logic       clk;
  logic       resetn;
  logic [3:0] req;
  logic [3:0] we;
  logic       ack;
  logic       idle;
  logic       read;
  logic       write;
  logic [3:0] grant;
  logic [1:0] grant_id;
  logic       timeout;

  int n_checks = 0;
  int n_fail   = 0;

  req_arb_fsm #(
    .N_CH   (4),
    .TIMEOUT(16)
  ) dut (
    .clk     (clk),
    .resetn  (resetn),
    .req     (req),
    .we      (we),
    .ack     (ack),
    .idle    (idle),
    .read    (read),
    .write   (write),
    .grant   (grant),
    .grant_id(grant_id),
    .timeout (timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    resetn = 1'b0;
    req    = '0;
    we     = '0;
    ack    = 1'b0;
    tick();
    tick();
    resetn = 1'b1;
    n_checks++;
    if ({idle, read, write, timeout} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_state: idle/read/write/timeout=%b required 1000",
               {idle, read, write, timeout});
    end
    n_checks++;
    if (grant !== 4'b0000 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_grant: grant=%b id=%0d required 0000 id 0", grant, grant_id);
    end
  endtask

  task automatic test_single_write();
    req = 4'b0100;
    we  = 4'b0100;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (write !== 1'b1 || read !== 1'b0 || idle !== 1'b0 || grant !== 4'b0100 ||
          grant_id !== 2'd2) begin
        n_fail++;
        $display("FAIL write_cycle%0d: write=%b read=%b idle=%b grant=%b id=%0d required 1 0 0 0100 2",
                 i, write, read, idle, grant, grant_id);
      end
    end
    ack = 1'b1;
    req = '0;
    tick();
    ack = 1'b0;
    n_checks++;
    if (idle !== 1'b1 || grant !== 4'b0000 || grant_id !== 2'd2) begin
      n_fail++;
      $display("FAIL write_done: idle=%b grant=%b id=%0d required 1 0000 2", idle, grant, grant_id);
    end
  endtask

  task automatic test_round_robin();
    int exp_id [5] = '{0, 1, 2, 3, 0};
    logic [3:0] exp_g;
    resetn = 1'b0;
    tick();
    resetn = 1'b1;
    req = 4'b1111;
    we  = 4'b0000;
    ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      exp_g = 4'b0001 << exp_id[i];
      tick();
      n_checks++;
      if (read !== 1'b1 || grant !== exp_g || grant_id !== 2'(exp_id[i])) begin
        n_fail++;
        $display("FAIL rr_grant%0d: read=%b grant=%b id=%0d required 1 %b %0d",
                 i, read, grant, grant_id, exp_g, exp_id[i]);
      end
      tick();
      n_checks++;
      if (idle !== 1'b1 || grant !== 4'b0000) begin
        n_fail++;
        $display("FAIL rr_gap%0d: idle=%b grant=%b required 1 0000", i, idle, grant);
      end
    end
  endtask

  task automatic test_wrap();
    req = 4'b1000;
    we  = 4'b0000;
    ack = 1'b1;
    tick();
    n_checks++;
    if (read !== 1'b1 || grant !== 4'b1000 || grant_id !== 2'd3) begin
      n_fail++;
      $display("FAIL wrap_first: read=%b grant=%b id=%0d required 1 1000 3", read, grant, grant_id);
    end
    req = 4'b1001;
    we  = 4'b0001;
    tick();
    tick();
    n_checks++;
    if (write !== 1'b1 || grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL wrap_next: write=%b grant=%b id=%0d required 1 0001 0",
               write, grant, grant_id);
    end
    req = '0;
    we  = '0;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_ack_idle();
    req = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
    tick();
    n_checks++;
    if ({idle, read, write, timeout} !== 4'b1000 || grant !== 4'b0000 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL ack_in_idle: state=%b grant=%b id=%0d required 1000 0000 0",
               {idle, read, write, timeout}, grant, grant_id);
    end
  endtask

  task automatic test_ignore_changes();
    req = 4'b0010;
    we  = 4'b0000;
    ack = 1'b0;
    tick();
    req = 4'b0000;
    we  = 4'b1111;
    tick();
    tick();
    n_checks++;
    if (read !== 1'b1 || grant !== 4'b0010 || grant_id !== 2'd1) begin
      n_fail++;
      $display("FAIL owner_drop: read=%b grant=%b id=%0d required 1 0010 1", read, grant, grant_id);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  task automatic test_watchdog();
    req = 4'b0001;
    we  = 4'b0000;
    ack = 1'b0;
    tick();
    req = '0;
    for (int i = 0; i < 16; i++) begin
      n_checks++;
      if (read !== 1'b1 || timeout !== 1'b0) begin
        n_fail++;
        $display("FAIL wd_read%0d: read=%b timeout=%b required 1 0", i, read, timeout);
      end
      tick();
    end
`ifdef REQ_ARB_FSM_TIMEOUT_EN
    n_checks++;
    if ({idle, read, write, timeout} !== 4'b0001 || grant !== 4'b0000) begin
      n_fail++;
      $display("FAIL wd_err: idle/read/write/timeout=%b grant=%b required 0001 0000",
               {idle, read, write, timeout}, grant);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (idle !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_after_err: idle=%b timeout=%b required 1 0", idle, timeout);
    end
`else
    n_checks++;
    if (read !== 1'b1 || timeout !== 1'b0 || grant !== 4'b0001) begin
      n_fail++;
      $display("FAIL no_wd_wait: read=%b timeout=%b grant=%b required 1 0 0001",
               read, timeout, grant);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
`endif
    // ack on the last allowed cycle completes normally
    req = 4'b0001;
    tick();
    req = '0;
    for (int i = 0; i < 15; i++) tick();
    n_checks++;
    if (read !== 1'b1) begin
      n_fail++;
      $display("FAIL wd_cycle16: read=%b required 1", read);
    end
    ack = 1'b1;
    tick();
    ack = 1'b0;
    n_checks++;
    if (idle !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_ack_wins: idle=%b timeout=%b required 1 0", idle, timeout);
    end
    tick();
    n_checks++;
    if (idle !== 1'b1 || timeout !== 1'b0) begin
      n_fail++;
      $display("FAIL wd_no_late_pulse: idle=%b timeout=%b required 1 0", idle, timeout);
    end
  endtask

  task automatic test_reset_mid();
    req = 4'b0100;
    we  = 4'b0100;
    ack = 1'b0;
    tick();
    tick();
    n_checks++;
    if (write !== 1'b1 || grant !== 4'b0100) begin
      n_fail++;
      $display("FAIL mid_setup: write=%b grant=%b required 1 0100", write, grant);
    end
    resetn = 1'b0;
    tick();
    n_checks++;
    if (idle !== 1'b1 || write !== 1'b0 || grant !== 4'b0000 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_reset: idle=%b write=%b grant=%b id=%0d required 1 0 0000 0",
               idle, write, grant, grant_id);
    end
    resetn = 1'b1;
    req    = 4'b1111;
    we     = 4'b0000;
    tick();
    n_checks++;
    if (read !== 1'b1 || grant !== 4'b0001 || grant_id !== 2'd0) begin
      n_fail++;
      $display("FAIL mid_rearb: read=%b grant=%b id=%0d required 1 0001 0", read, grant, grant_id);
    end
    req = '0;
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_round_robin();
    test_wrap();
    test_ack_idle();
    test_ignore_changes();
    test_watchdog();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
